pbkdf2_block_sched: RTL and testbench
=====================================

Name: pbkdf2_block_sched

Overview:
- Job scheduler between the KDA input channel and a pool of NUM_CORES pbkdf2 cores.
- Accepts one key-derivation job: pass, salt, salt_len, iters, and a block count of 1..4 × 256-bit blocks.
- Dispatches each block index to a free core, collects the hashes out of order, and presents the assembled 1024-bit result on a valid/yumi port.
- With it, output length is no longer tied to a fixed core-per-chunk wiring: fewer cores serialise, more cores overlap.

Parameters:
- NUM_CORES, 4, number of pbkdf2 cores in the pool (1..8).
- MAX_BLOCKS, 4, maximum 256-bit blocks per job; fixes hash_o width at MAX_BLOCKS*256.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- job_v_i  in  1  job valid
- job_ready_o  out  1  job accepted when job_v_i & job_ready_o
- chunks_i  in  2  block count minus 1
- salt_len_i  in  6  salt length in bytes
- iters_i  in  32  iteration count
- pass_i  in  512  password
- salt_i  in  512  salt
- core_v_o  out  NUM_CORES  per-core start valid
- core_ready_i  in  NUM_CORES  per-core input ready
- core_blk_o  out  2  block index (0-based) for the core being started
- core_salt_len_o / core_iters_o / core_pass_o / core_salt_o  out  6/32/512/512  registered job fields, shared bus
- core_out_v_i  in  NUM_CORES  per-core hash valid
- core_yumi_o  out  NUM_CORES  per-core hash consumed
- core_hash_i  in  NUM_CORES*256  flat core hashes, core k at [k*256 +: 256]
- hash_o  out  MAX_BLOCKS*256  result; block 0 in the MSBs, unfilled blocks zero
- v_o  out  1  result valid
- yumi_i  in  1  result consumed

Behaviour:
- Reset: clock clk_i, reset reset_i, synchronous active-high. FSM=IDLE; job_ready_o=0 in reset cycle, 1 after; core_v_o=0; core_yumi_o=0; v_o=0; hash_o=0; busy/tag/counters cleared. Reset mid-job abandons the job; cores share reset_i.
- IDLE: job_ready_o=1.
  - On handshake: latch all job fields; nblk=chunks_i+1; next_blk=0; done_cnt=0; clear hash buffer; go to DISPATCH.
- DISPATCH: job_ready_o=0.
  - Each cycle select one core k that is not busy and has core_ready_i[k]=1; choose round-robin starting after the last granted core.
  - Drive core_v_o one-hot at k and core_blk_o=next_blk.
  - On core_v_o[k] & core_ready_i[k]: set busy[k], tag[k]=next_blk, next_blk++.
  - core_v_o must not drop while the selected core stays ready.
  - When next_blk==nblk after a grant, go to WAIT.
  - No free ready core: core_v_o=0; wait.
- Collection (DISPATCH and WAIT): among cores with busy[k] & core_out_v_i[k], pick the lowest index.
  - Assert core_yumi_o[k] combinationally in the same cycle.
  - Write core_hash_i[k] into hash slot tag[k], i.e. bits [(MAX_BLOCKS-1-tag)*256 +: 256].
  - Clear busy[k]; done_cnt++.
  - At most one collection per cycle.
  - core_out_v_i from a non-busy core is ignored: no yumi, no write.
- Collect and dispatch on the same core in the same cycle is allowed: the freed core is not eligible until the next cycle.
- WAIT → DONE when done_cnt reaches nblk, counting the collection in that cycle.
- DONE: v_o=1; hash_o stable.
  - On yumi_i: v_o=0 next cycle, go to IDLE.
  - yumi_i while v_o=0 is ignored.
- Latency:
  - job handshake → first core_v_o: 1 cycle.
  - last collection → v_o: 1 cycle.
- Widths:
  - next_blk and done_cnt are 3 bits; no wrap for nblk≤4.
  - Round-robin pointer is $clog2(NUM_CORES) bits and wraps modulo NUM_CORES.

Decomposition:
- Package pbkdf2_sched_pkg holds:
  - state enum {IDLE, DISPATCH, WAIT, DONE}
  - HASH_W=256, PASS_W=512, SALT_W=512, ITERS_W=32, SALT_LEN_W=6
- One sub-module: rr_arb (NUM_CORES-wide round-robin arbiter with request, grant and advance-on-accept).
- Collection priority is a plain lowest-index priority encoder inline.

Test Plan:
- Reset: reset_i high 3 cycles mid-DISPATCH with chunks=3 → core_v_o=0, v_o=0, job_ready_o=1 the cycle after release; stale core_out_v_i produces no core_yumi_o.
- Single block, NUM_CORES=4: chunks=0, iters=1 → exactly one core_v_o pulse with core_blk_o=0; core returns 0xAA..AA → hash_o[1023:768]=0xAA..AA, rest 0, v_o one cycle after yumi.
- Out-of-order completion: chunks=3, cores finish in order blk2, blk0, blk3, blk1 with hashes 0x22.., 0x00.., 0x33.., 0x11.. → hash_o = {0x00..,0x11..,0x22..,0x33..}.
- Serialisation, NUM_CORES=1: chunks=3 → core_blk_o sequence 0,1,2,3, each issued only after the previous yumi; final hash_o ordered correctly.
- Simultaneous done: cores 1 and 3 assert core_out_v_i in the same cycle → core_yumi_o=0b0010 that cycle, 0b1000 the next; done_cnt increments by 1 each.
- Backpressure: v_o held 10 cycles with yumi_i=0 → hash_o stable, job_ready_o=0; yumi_i then pulsed → new job accepted one cycle later.

Source files
------------

// File: rtl/pbkdf2_sched_pkg.sv
// Shared types and widths for the pbkdf2 block scheduler.
package pbkdf2_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        WAIT     = 2'd2,
        DONE     = 2'd3
    } state_e;

    localparam int HASH_W     = 256;
    localparam int PASS_W     = 512;
    localparam int SALT_W     = 512;
    localparam int ITERS_W    = 32;
    localparam int SALT_LEN_W = 6;
    localparam int BLK_W      = 2;  // block index width (up to 4 blocks)
    localparam int CNT_W      = 3;  // next_blk / done_cnt / nblk: holds 0..4 without wrap

endpackage

// File: rtl/pbkdf2_block_sched_rr_arb.sv
// Round-robin arbiter: searches from the core after the last accepted grant.
// The pointer only moves on an accepted grant, so an unaccepted selection is stable.
module rr_arb #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [N-1:0] req_i,
    input  logic         adv_i,
    output logic [N-1:0] gnt_o
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win;
    logic          found;
    int            idx;

    // Rotating priority search starting at ptr_q+1, modulo N.
    always_comb begin
        gnt_o = '0;
        win   = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + 1 + i) % N;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                win        = PW'(idx);
            end
        end
        ptr_d = (adv_i && found) ? win : ptr_q;
    end

    // Pointer register; reset to the last core so core 0 wins first.
    always_ff @(posedge clk_i) begin
        if (reset_i) ptr_q <= PW'(N - 1);
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/pbkdf2_block_sched.sv
// Schedules the 256-bit blocks of one key-derivation job across a pool of
// pbkdf2 cores, gathers results out of order and presents the assembled hash.
module pbkdf2_block_sched
    import pbkdf2_sched_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int MAX_BLOCKS = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         job_v_i,
    output logic                         job_ready_o,
    input  logic [1:0]                   chunks_i,
    input  logic [SALT_LEN_W-1:0]        salt_len_i,
    input  logic [ITERS_W-1:0]           iters_i,
    input  logic [PASS_W-1:0]            pass_i,
    input  logic [SALT_W-1:0]            salt_i,
    output logic [NUM_CORES-1:0]         core_v_o,
    input  logic [NUM_CORES-1:0]         core_ready_i,
    output logic [BLK_W-1:0]             core_blk_o,
    output logic [SALT_LEN_W-1:0]        core_salt_len_o,
    output logic [ITERS_W-1:0]           core_iters_o,
    output logic [PASS_W-1:0]            core_pass_o,
    output logic [SALT_W-1:0]            core_salt_o,
    input  logic [NUM_CORES-1:0]         core_out_v_i,
    output logic [NUM_CORES-1:0]         core_yumi_o,
    input  logic [NUM_CORES*HASH_W-1:0]  core_hash_i,
    output logic [MAX_BLOCKS*HASH_W-1:0] hash_o,
    output logic                         v_o,
    input  logic                         yumi_i
);
    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                nblk_q, nblk_d;
    logic [CNT_W-1:0]                next_blk_q, next_blk_d;
    logic [CNT_W-1:0]                done_cnt_q, done_cnt_d;
    logic [NUM_CORES-1:0]            busy_q, busy_d;
    logic [NUM_CORES-1:0][BLK_W-1:0] tag_q, tag_d;
    logic [MAX_BLOCKS*HASH_W-1:0]    hash_q, hash_d;
    logic [SALT_LEN_W-1:0]           salt_len_q, salt_len_d;
    logic [ITERS_W-1:0]              iters_q, iters_d;
    logic [PASS_W-1:0]               pass_q, pass_d;
    logic [SALT_W-1:0]               salt_q, salt_d;

    logic                 job_hs;
    logic [NUM_CORES-1:0] arb_req, arb_gnt;
    logic                 disp_fire;
    logic [NUM_CORES-1:0] col_req;
    logic                 col_any;
    int                   col_idx;

    assign job_hs = job_v_i & job_ready_o;

    // Only idle, currently-ready cores compete; a core freed this cycle still
    // shows busy_q and so only becomes eligible next cycle.
    assign arb_req   = (state_q == DISPATCH) ? (~busy_q & core_ready_i) : '0;
    assign core_v_o  = reset_i ? '0 : arb_gnt;
    assign disp_fire = |core_v_o;

    rr_arb #(.N(NUM_CORES)) u_arb (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .req_i   (arb_req),
        .adv_i   (disp_fire),
        .gnt_o   (arb_gnt)
    );

    // Lowest-index completing busy core wins the single collection slot.
    always_comb begin
        col_req     = ((state_q == DISPATCH || state_q == WAIT) && !reset_i)
                      ? (busy_q & core_out_v_i) : '0;
        col_any     = |col_req;
        col_idx     = 0;
        core_yumi_o = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (col_req[k]) col_idx = k;
        end
        if (col_any) core_yumi_o[col_idx] = 1'b1;
    end

    // Job latch, dispatch bookkeeping and result assembly.
    always_comb begin
        nblk_d     = nblk_q;
        next_blk_d = next_blk_q;
        done_cnt_d = done_cnt_q;
        busy_d     = busy_q;
        tag_d      = tag_q;
        hash_d     = hash_q;
        salt_len_d = salt_len_q;
        iters_d    = iters_q;
        pass_d     = pass_q;
        salt_d     = salt_q;
        if (state_q == IDLE && job_hs) begin
            salt_len_d = salt_len_i;
            iters_d    = iters_i;
            pass_d     = pass_i;
            salt_d     = salt_i;
            nblk_d     = {1'b0, chunks_i} + 3'd1;
            next_blk_d = '0;
            done_cnt_d = '0;
            busy_d     = '0;
            hash_d     = '0;
        end
        if (disp_fire) begin
            busy_d     = busy_d | core_v_o;
            next_blk_d = next_blk_q + 3'd1;
            for (int k = 0; k < NUM_CORES; k++) begin
                if (core_v_o[k]) tag_d[k] = next_blk_q[BLK_W-1:0];
            end
        end
        if (col_any) begin
            busy_d[col_idx] = 1'b0;
            done_cnt_d      = done_cnt_q + 3'd1;
            // Block b lands in slot b counted from the MSB end.
            for (int b = 0; b < MAX_BLOCKS; b++) begin
                if (tag_q[col_idx] == BLK_W'(b))
                    hash_d[(MAX_BLOCKS-1-b)*HASH_W +: HASH_W] =
                        core_hash_i[col_idx*HASH_W +: HASH_W];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (job_hs) state_d = DISPATCH;
            DISPATCH: if (disp_fire && (next_blk_q + 3'd1) == nblk_q) state_d = WAIT;
            WAIT:     if (done_cnt_d == nblk_q) state_d = DONE;
            DONE:     if (yumi_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FSM-decoded outputs.
    always_comb begin
        job_ready_o = (state_q == IDLE) && !reset_i;
        v_o         = (state_q == DONE);
    end

    assign core_blk_o      = next_blk_q[BLK_W-1:0];
    assign core_salt_len_o = salt_len_q;
    assign core_iters_o    = iters_q;
    assign core_pass_o     = pass_q;
    assign core_salt_o     = salt_q;
    assign hash_o          = hash_q;

    // State and datapath registers; reset abandons any job in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            nblk_q     <= '0;
            next_blk_q <= '0;
            done_cnt_q <= '0;
            busy_q     <= '0;
            tag_q      <= '0;
            hash_q     <= '0;
            salt_len_q <= '0;
            iters_q    <= '0;
            pass_q     <= '0;
            salt_q     <= '0;
        end else begin
            state_q    <= state_d;
            nblk_q     <= nblk_d;
            next_blk_q <= next_blk_d;
            done_cnt_q <= done_cnt_d;
            busy_q     <= busy_d;
            tag_q      <= tag_d;
            hash_q     <= hash_d;
            salt_len_q <= salt_len_d;
            iters_q    <= iters_d;
            pass_q     <= pass_d;
            salt_q     <= salt_d;
        end
    end

endmodule

// File: tb/tb_pbkdf2_block_sched.sv
// Directed bench: a 4-core instance driven from a vector table plus hand
// sequences, and a 1-core instance for serialised dispatch.
module tb_pbkdf2_block_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         job_v, yumi, job_ready, v;
    logic [1:0]   chunks, core_blk;
    logic [5:0]   salt_len, c_salt_len;
    logic [31:0]  iters, c_iters;
    logic [511:0] pass, salt, c_pass, c_salt;
    logic [3:0]   core_v, core_ready, core_out_v, core_yumi;
    logic [1023:0] core_hash, hash;

    logic         job_v1, yumi1, job_ready1, v1;
    logic [1:0]   chunks1, core_blk1;
    logic [5:0]   c1_salt_len;
    logic [31:0]  c1_iters;
    logic [511:0] c1_pass, c1_salt;
    logic [0:0]   core_v1, core_ready1, core_out_v1, core_yumi1;
    logic [255:0] core_hash1;
    logic [1023:0] hash1;

    pbkdf2_block_sched #(.NUM_CORES(4), .MAX_BLOCKS(4)) dut (
        .clk_i(clk), .reset_i(rst), .job_v_i(job_v), .job_ready_o(job_ready),
        .chunks_i(chunks), .salt_len_i(salt_len), .iters_i(iters), .pass_i(pass), .salt_i(salt),
        .core_v_o(core_v), .core_ready_i(core_ready), .core_blk_o(core_blk),
        .core_salt_len_o(c_salt_len), .core_iters_o(c_iters), .core_pass_o(c_pass), .core_salt_o(c_salt),
        .core_out_v_i(core_out_v), .core_yumi_o(core_yumi), .core_hash_i(core_hash),
        .hash_o(hash), .v_o(v), .yumi_i(yumi)
    );

    pbkdf2_block_sched #(.NUM_CORES(1), .MAX_BLOCKS(4)) dut1 (
        .clk_i(clk), .reset_i(rst), .job_v_i(job_v1), .job_ready_o(job_ready1),
        .chunks_i(chunks1), .salt_len_i(salt_len), .iters_i(iters), .pass_i(pass), .salt_i(salt),
        .core_v_o(core_v1), .core_ready_i(core_ready1), .core_blk_o(core_blk1),
        .core_salt_len_o(c1_salt_len), .core_iters_o(c1_iters), .core_pass_o(c1_pass), .core_salt_o(c1_salt),
        .core_out_v_i(core_out_v1), .core_yumi_o(core_yumi1), .core_hash_i(core_hash1),
        .hash_o(hash1), .v_o(v1), .yumi_i(yumi1)
    );

    typedef struct packed {
        logic [1:0]      chunks;
        logic [3:0][1:0] ord;   // completion order, by block index
        logic [3:0][7:0] hb;    // hash byte returned for block b
        logic [3:0][7:0] exp;   // expected byte in result slot s
        logic [3:0]      hold;  // cycles v_o is held before yumi
    } vec_t;

    int total = 0;
    int passed = 0;
    int core_of [4];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [1:0] ch,
                                input logic [1:0] o0, o1, o2, o3,
                                input logic [7:0] h0, h1, h2, h3,
                                input logic [7:0] e0, e1, e2, e3,
                                input logic [3:0] hold);
        vec_t r;
        r.chunks = ch;
        r.ord[0] = o0; r.ord[1] = o1; r.ord[2] = o2; r.ord[3] = o3;
        r.hb[0]  = h0; r.hb[1]  = h1; r.hb[2]  = h2; r.hb[3]  = h3;
        r.exp[0] = e0; r.exp[1] = e1; r.exp[2] = e2; r.exp[3] = e3;
        r.hold   = hold;
        return r;
    endfunction

    // Handshake one job on the 4-core instance.
    task automatic start4(input logic [1:0] ch);
        job_v    = 1'b1;
        chunks   = ch;
        iters    = $urandom;
        salt_len = 6'($urandom_range(1, 63));
        pass     = {16{$urandom}};
        salt     = {16{$urandom}};
        @(negedge clk);
        chk("job_ready", job_ready, 1'b1);
        tick;
        job_v = 1'b0;
    endtask

    // Expect one grant per cycle, block indices in order; record core per block.
    task automatic dispatch4(input int n, input bit check_core);
        logic [31:0] it;
        it = iters;
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            chk("grant_onehot", $onehot(core_v), 1'b1);
            chk("core_blk", core_blk, b[1:0]);
            if (b == 0) chk("core_iters", c_iters, it);
            core_of[b] = 0;
            for (int k = 0; k < 4; k++) if (core_v[k]) core_of[b] = k;
            if (check_core) chk("rr_core", core_of[b], b);
            tick;
        end
    endtask

    task automatic complete4(input int blk, input logic [7:0] byt);
        core_out_v = 4'b0001 << core_of[blk];
        core_hash[core_of[blk]*256 +: 256] = {32{byt}};
        @(negedge clk);
        chk("yumi", core_yumi, 4'b0001 << core_of[blk]);
        tick;
        core_out_v = '0;
    endtask

    task automatic finish4(input logic [3:0][7:0] exp, input int hold);
        logic [1023:0] held;
        @(negedge clk);
        chk("v_o", v, 1'b1);
        for (int s = 0; s < 4; s++) chk("hash_slot", hash[(3-s)*256 +: 256], {32{exp[s]}});
        held = {{32{exp[0]}}, {32{exp[1]}}, {32{exp[2]}}, {32{exp[3]}}};
        for (int h = 0; h < hold; h++) begin
            tick;
            @(negedge clk);
            chk("hold_v", v, 1'b1);
            chk("hold_ready", job_ready, 1'b0);
            chk("hold_hash_stable", hash === held, 1'b1);
        end
        tick;
        yumi = 1'b1;
        @(negedge clk);
        chk("v_before_yumi_edge", v, 1'b1);
        tick;
        yumi = 1'b0;
        @(negedge clk);
        chk("v_after_yumi", v, 1'b0);
        chk("ready_after_yumi", job_ready, 1'b1);
        tick;
    endtask

    vec_t vt [4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = mk(2'd0, 0,0,0,0, 8'hAA,8'h00,8'h00,8'h00, 8'hAA,8'h00,8'h00,8'h00, 4'd0);
        vt[1] = mk(2'd3, 2,0,3,1, 8'h00,8'h11,8'h22,8'h33, 8'h00,8'h11,8'h22,8'h33, 4'd10);
        vt[2] = mk(2'd1, 1,0,0,0, 8'h5A,8'hC3,8'h00,8'h00, 8'h5A,8'hC3,8'h00,8'h00, 4'd0);
        vt[3] = mk(2'd2, 0,2,1,0, 8'h01,8'h02,8'h03,8'h00, 8'h01,8'h02,8'h03,8'h00, 4'd2);

        rst = 1'b1; job_v = 0; yumi = 0; chunks = 0; salt_len = 0; iters = 0;
        pass = '0; salt = '0; core_ready = 4'hF; core_out_v = '0; core_hash = '0;
        job_v1 = 0; yumi1 = 0; chunks1 = 0; core_ready1 = 1'b1; core_out_v1 = '0; core_hash1 = '0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", job_ready, 1'b0);
        chk("rst_v", v, 1'b0);
        chk("rst_core_v", core_v, 4'h0);
        chk("rst_hash", hash[1023:768], '0);
        tick; tick; tick;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", job_ready, 1'b1);
        tick;

        // Simultaneous completion on cores 1 and 3
        start4(2'd3);
        dispatch4(4, 1'b1);
        core_hash = {{32{8'hE3}}, {32{8'hE2}}, {32{8'hE1}}, {32{8'hE0}}};
        core_out_v = 4'b1010;
        @(negedge clk);
        chk("simul_yumi_a", core_yumi, 4'b0010);
        tick;
        core_out_v = 4'b1000;
        @(negedge clk);
        chk("simul_yumi_b", core_yumi, 4'b1000);
        tick;
        core_out_v = 4'b0101;
        @(negedge clk);
        chk("simul_yumi_c", core_yumi, 4'b0001);
        tick;
        core_out_v = 4'b0100;
        @(negedge clk);
        chk("simul_yumi_d", core_yumi, 4'b0100);
        chk("simul_v_early", v, 1'b0);
        tick;
        core_out_v = '0;
        finish4({8'hE3, 8'hE2, 8'hE1, 8'hE0}, 0);

        // Table-driven jobs
        for (int i = 0; i < 4; i++) begin
            int n;
            n = int'(vt[i].chunks) + 1;
            start4(vt[i].chunks);
            dispatch4(n, 1'b0);
            for (int j = 0; j < n; j++)
                complete4(int'(vt[i].ord[j]), vt[i].hb[vt[i].ord[j]]);
            finish4(vt[i].exp, int'(vt[i].hold));
        end

        // Reset mid-dispatch with stale completions
        start4(2'd3);
        rst = 1'b1;
        core_out_v = 4'hF;
        tick; tick; tick;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_core_v", core_v, 4'h0);
        chk("midrst_v", v, 1'b0);
        chk("midrst_ready", job_ready, 1'b1);
        chk("midrst_yumi", core_yumi, 4'h0);
        tick;
        core_out_v = '0;

        // Single-core serialisation
        job_v1 = 1'b1;
        chunks1 = 2'd3;
        @(negedge clk);
        chk("s_job_ready", job_ready1, 1'b1);
        tick;
        job_v1 = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < 20; w++) begin
                @(negedge clk);
                if (core_v1[0]) break;
                tick;
            end
            chk("s_grant_seen", core_v1, 1'b1);
            chk("s_blk", core_blk1, b[1:0]);
            tick;
            @(negedge clk);
            chk("s_no_issue_busy", core_v1, 1'b0);
            tick;
            core_out_v1 = 1'b1;
            core_hash1 = {32{8'(8'h10 + b)}};
            @(negedge clk);
            chk("s_yumi", core_yumi1, 1'b1);
            chk("s_no_reuse_same_cycle", core_v1, 1'b0);
            tick;
            core_out_v1 = 1'b0;
        end
        @(negedge clk);
        chk("s_v", v1, 1'b1);
        for (int s = 0; s < 4; s++)
            chk("s_hash_slot", hash1[(3-s)*256 +: 256], {32{8'(8'h10 + s)}});
        tick;
        yumi1 = 1'b1;
        tick;
        yumi1 = 1'b0;
        @(negedge clk);
        chk("s_v_cleared", v1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
